reg_file_sb: RTL

- Parametrised successor to the 16-bit 32-entry register file: configurable data width and depth, two synchronous (registered) read ports, one write port.
- Adds write-to-read forwarding, an optional hardwired-zero register 0, and an async reset that clears all state.
- Adds a per-register pending-write scoreboard (busy bits), so the pipeline's hazard unit can stall on operands that have not yet been written back.

---
 rtl/reg_file_sb.sv | 127 ++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Parametrised register file: two registered read ports, one write port,
// write-to-read forwarding, optional hardwired-zero r0 and a pending-write scoreboard.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_valid,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic              busy_1,
  output logic              busy_2
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;

  logic              wr_zero;
  logic              rd1_zero;
  logic              rd2_zero;
  logic              res_zero;
  logic              wr_ok;
  logic              res_ok;
  logic              fwd_1;
  logic              fwd_2;
  logic              release_1;
  logic              release_2;
  logic [DATA_W-1:0] rd_next_1;
  logic [DATA_W-1:0] rd_next_2;

  assign wr_zero  = ZR && (write_addr   == '0);
  assign rd1_zero = ZR && (read_addr_1  == '0);
  assign rd2_zero = ZR && (read_addr_2  == '0);
  assign res_zero = ZR && (reserve_addr == '0);

  assign wr_ok  = RegWrite && !wr_zero;
  assign res_ok = reserve_en && !res_zero;

  // a write landing on the same edge as a read is forwarded to that read
  assign fwd_1 = wr_ok && (write_addr == read_addr_1);
  assign fwd_2 = wr_ok && (write_addr == read_addr_2);

  always_comb begin
    rd_next_1 = regs[read_addr_1];
    if (rd1_zero) begin
      rd_next_1 = '0;
    end else if (fwd_1) begin
      rd_next_1 = write_data;
    end
  end

  always_comb begin
    rd_next_2 = regs[read_addr_2];
    if (rd2_zero) begin
      rd_next_2 = '0;
    end else if (fwd_2) begin
      rd_next_2 = write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[write_addr] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_1 <= '0;
      read_data_2 <= '0;
      read_valid  <= 1'b0;
    end else begin
      read_valid <= read_en;
      if (read_en) begin
        read_data_1 <= rd_next_1;
        read_data_2 <= rd_next_2;
      end
    end
  end

  // clear first, then set: a reservation on the writeback edge belongs to a newer producer
  always_comb begin
    busy_next = busy;
    if (RegWrite) begin
      busy_next[write_addr] = 1'b0;
    end
    if (res_ok) begin
      busy_next[reserve_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // current-cycle writeback releases the hazard, matching what forwarding delivers
  assign release_1 = RegWrite && (write_addr == read_addr_1) &&
                     !(reserve_en && (reserve_addr == write_addr));
  assign release_2 = RegWrite && (write_addr == read_addr_2) &&
                     !(reserve_en && (reserve_addr == write_addr));

  assign busy_1 = busy[read_addr_1] && !release_1;
  assign busy_2 = busy[read_addr_2] && !release_2;

endmodule
